// File: rtl/ft_rx_packer.sv
// ft_rx_packer: FT232H synchronous-FIFO receive front end.
// Drives the FTDI read handshake, buffers bytes in a 4-entry skid FIFO and
// parses SYNC/LEN/ADDR/DATA packets into one SDRAM write request per word.
module ft_rx_packer #(
  parameter int          ADDR_W    = 22,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              ft_clk,
  input  logic              reset,
  input  logic              ft_rxf,
  input  logic [7:0]        ft_d,
  output logic              ft_oe,
  output logic              ft_rd,
  output logic              ft_wr,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              pkt_err,
  output logic              busy
);

  typedef enum logic [1:0] {B_IDLE, B_OE, B_READ} bstate_t;
  typedef enum logic [2:0] {P_SYNC, P_LEN, P_A0, P_A1, P_A2, P_DLO, P_DHI, P_WAIT} pstate_t;

  bstate_t           r_bstate;
  pstate_t           r_pstate;
  logic [7:0]        r_mem [4];
  logic [1:0]        r_wptr, r_rptr;
  logic [2:0]        r_cnt;
  logic              r_oe, r_rd;
  logic [8:0]        r_wcnt;
  logic [15:0]       r_a16;
  logic [7:0]        r_dlo;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_data;
  logic              r_req, r_err;

  logic              w_push, w_pop;
  logic [2:0]        w_cnt_nxt;
  logic [7:0]        w_byte;
  logic [23:0]       w_a24;

  // A byte lands on every edge spent in B_READ with data available; the
  // parser pops whenever it holds no pending request and the FIFO has data.
  assign w_push    = (r_bstate == B_READ) && !ft_rxf;
  assign w_pop     = (r_cnt != 3'd0) && (r_pstate != P_WAIT);
  assign w_cnt_nxt = r_cnt + 3'(w_push) - 3'(w_pop);
  assign w_byte    = r_mem[r_rptr];
  assign w_a24     = {w_byte, r_a16};

  assign ft_oe   = r_oe;
  assign ft_rd   = r_rd;
  assign ft_wr   = 1'b1;
  assign wr_req  = r_req;
  assign wr_addr = r_addr;
  assign wr_data = r_data;
  assign pkt_err = r_err;
  assign busy    = (r_pstate != P_SYNC) || (r_cnt != 3'd0);

  // FIFO storage; contents need no reset, pointers/occupancy guard them.
  always_ff @(posedge ft_clk) begin
    if (w_push) r_mem[r_wptr] <= ft_d;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge ft_clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop)  r_rptr <= r_rptr + 2'd1;
      r_cnt <= w_cnt_nxt;
    end
  end

  // FTDI read handshake. Only start a burst with 3 free entries and stop once
  // occupancy reaches 3, so the FIFO can never be overrun.
  always_ff @(posedge ft_clk) begin
    if (reset) begin
      r_bstate <= B_IDLE;
      r_oe     <= 1'b1;
      r_rd     <= 1'b1;
    end else begin
      case (r_bstate)
        B_IDLE: if (!ft_rxf && r_cnt <= 3'd1) begin
          r_bstate <= B_OE;
          r_oe     <= 1'b0;
        end
        B_OE: begin
          r_bstate <= B_READ;
          r_rd     <= 1'b0;
        end
        B_READ: if (ft_rxf || w_cnt_nxt >= 3'd3) begin
          r_bstate <= B_IDLE;
          r_oe     <= 1'b1;
          r_rd     <= 1'b1;
        end
        default: begin
          r_bstate <= B_IDLE;
          r_oe     <= 1'b1;
          r_rd     <= 1'b1;
        end
      endcase
    end
  end

  // Packet parser; holds the write request until it is acknowledged.
  always_ff @(posedge ft_clk) begin
    if (reset) begin
      r_pstate <= P_SYNC;
      r_wcnt   <= '0;
      r_a16    <= '0;
      r_dlo    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_req    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_pstate)
        P_SYNC: if (w_pop) begin
          if (w_byte == SYNC_BYTE) r_pstate <= P_LEN;
          else                     r_err    <= 1'b1;
        end
        P_LEN: if (w_pop) begin
          r_wcnt   <= (w_byte == 8'd0) ? 9'd256 : {1'b0, w_byte};
          r_pstate <= P_A0;
        end
        P_A0: if (w_pop) begin
          r_a16[7:0] <= w_byte;
          r_pstate   <= P_A1;
        end
        P_A1: if (w_pop) begin
          r_a16[15:8] <= w_byte;
          r_pstate    <= P_A2;
        end
        P_A2: if (w_pop) begin
          r_addr   <= w_a24[ADDR_W-1:0];
          r_pstate <= P_DLO;
        end
        P_DLO: if (w_pop) begin
          r_dlo    <= w_byte;
          r_pstate <= P_DHI;
        end
        P_DHI: if (w_pop) begin
          r_data   <= {w_byte, r_dlo};
          r_req    <= 1'b1;
          r_pstate <= P_WAIT;
        end
        P_WAIT: if (wr_ack) begin
          r_req    <= 1'b0;
          r_addr   <= r_addr + ADDR_W'(1);
          r_wcnt   <= r_wcnt - 9'd1;
          r_pstate <= (r_wcnt == 9'd1) ? P_SYNC : P_DLO;
        end
        default: r_pstate <= P_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_ft_rx_packer.sv
// Bench for ft_rx_packer: FTDI byte-source emulator, acking sink, and a
// scoreboard of expected write requests checked by an independent monitor.
module tb_ft_rx_packer;
  localparam int AW = 22;

  logic          ft_clk = 1'b0;
  logic          reset  = 1'b1;
  logic          ft_rxf = 1'b1;
  logic [7:0]    ft_d   = 8'h00;
  logic          wr_ack = 1'b0;
  logic          ft_oe, ft_rd, ft_wr, wr_req, pkt_err, busy;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;

  ft_rx_packer #(.ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
    .ft_clk(ft_clk), .reset(reset), .ft_rxf(ft_rxf), .ft_d(ft_d),
    .ft_oe(ft_oe), .ft_rd(ft_rd), .ft_wr(ft_wr),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_data(wr_data),
    .pkt_err(pkt_err), .busy(busy)
  );

  always #8 ft_clk = ~ft_clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } req_t;

  req_t       sb[$];
  logic [7:0] src_q[$];
  int checks = 0, errors = 0;
  int cyc = 0, sync_cyc = 0;
  bit lat_arm = 0, burst = 0;
  int ack_delay = 0, ack_wait = 0;
  int err_seen = 0, rd_stall = 0;
  req_t cap;
  logic p_req = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [15:0] p_data = '0;
  logic oe1 = 1'b1, oe2 = 1'b1, rd1 = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // FTDI emulator: a byte is consumed on each edge with rd and rxf low.
  always @(posedge ft_clk) begin : emu
    bit take;
    cyc++;
    take = !reset && !ft_rd && !ft_rxf;
    if (take && lat_arm && sync_cyc == 0) sync_cyc = cyc;
    #1;
    if (take && src_q.size() > 0) void'(src_q.pop_front());
    ft_rxf = !(src_q.size() > 0 && (!burst || ((cyc / 3) % 2 == 0)));
    ft_d   = (src_q.size() > 0) ? src_q[0] : 8'h00;
  end

  // Monitor and sink: handshake rules, request stability, scoreboard, acks.
  always @(negedge ft_clk) begin : mon
    req_t e;
    if (pkt_err) err_seen++;
    if (ft_rd && !ft_rxf) rd_stall++;
    if (rd1 && !ft_rd) begin
      chk("oe_low_before_rd", 32'(oe1), 32'd0);
      chk("oe_lead_one_cycle", 32'(oe2), 32'd1);
    end
    oe2 = oe1; oe1 = ft_oe; rd1 = ft_rd;
    if (p_req && wr_req) begin
      chk("req_addr_stable", 32'(wr_addr), 32'(p_addr));
      chk("req_data_stable", 32'(wr_data), 32'(p_data));
    end
    if (!p_req && wr_req && lat_arm) begin
      chk("first_req_latency", 32'(cyc - sync_cyc), 32'd7);
      lat_arm = 0;
    end
    p_req = wr_req; p_addr = wr_addr; p_data = wr_data;
    if (wr_ack) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_req: got addr %0h data %0h expected none", cap.a, cap.d);
      end else begin
        e = sb.pop_front();
        chk("req_addr", 32'(cap.a), 32'(e.a));
        chk("req_data", 32'(cap.d), 32'(e.d));
      end
      wr_ack = 1'b0;
    end else if (wr_req && !reset) begin
      if (ack_wait >= ack_delay) begin
        cap.a = wr_addr; cap.d = wr_data;
        wr_ack = 1'b1; ack_wait = 0;
      end else ack_wait++;
    end else ack_wait = 0;
  end

  // Queue one packet's bytes on the source and its requests on the scoreboard.
  task automatic send_pkt(input logic [AW-1:0] addr, input int n, input logic [15:0] base,
                          input logic [15:0] step, input logic [1:0] junk);
    logic [23:0] a24;
    logic [15:0] d;
    req_t r;
    a24 = {junk, addr};
    src_q.push_back(8'hA5);
    src_q.push_back(8'(n));
    src_q.push_back(a24[7:0]);
    src_q.push_back(a24[15:8]);
    src_q.push_back(a24[23:16]);
    for (int i = 0; i < n; i++) begin
      d = base + 16'(i) * step;
      src_q.push_back(d[7:0]);
      src_q.push_back(d[15:8]);
      r.a = addr + AW'(i);
      r.d = d;
      sb.push_back(r);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((src_q.size() != 0 || sb.size() != 0 || wr_req || wr_ack) && n < 5000) begin
      @(negedge ft_clk);
      n++;
    end
    if (n >= 5000) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d pending requests expected 0", nm, sb.size());
    end
    repeat (2) @(negedge ft_clk);
    chk({nm, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin : wdog
    #2ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin : main
    int eb;
    repeat (3) @(negedge ft_clk);
    chk("rst_oe",   32'(ft_oe),   32'd1);
    chk("rst_rd",   32'(ft_rd),   32'd1);
    chk("rst_wr",   32'(ft_wr),   32'd1);
    chk("rst_req",  32'(wr_req),  32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", 32'(wr_data), 32'd0);
    chk("rst_err",  32'(pkt_err), 32'd0);
    chk("rst_busy", 32'(busy),    32'd0);
    reset = 1'b0;
    repeat (3) @(negedge ft_clk);

    // 1: single word A5 01 10 00 00 34 12, minimum latency
    sync_cyc = 0; lat_arm = 1;
    send_pkt(22'h000010, 1, 16'h1234, 16'h0000, 2'b00);
    wait_idle("t1");
    chk("t1_latency_seen", 32'(lat_arm), 32'd0);

    // 2: back-pressure with a wrapping address
    ack_delay = 20; rd_stall = 0;
    send_pkt(22'h3FFFFE, 8, 16'hC0DE, 16'h1111, 2'b00);
    wait_idle("t2");
    chk("t2_rd_deasserted", 32'(rd_stall > 0), 32'd1);

    // 3: LEN=0 means 256 words; junk in the unused address bits
    ack_delay = 0;
    send_pkt(22'h001000, 256, 16'h0000, 16'h0101, 2'b11);
    wait_idle("t3");

    // 4: two garbage bytes, then a valid packet
    eb = err_seen;
    src_q.push_back(8'h00);
    src_q.push_back(8'hFF);
    send_pkt(22'h2AAAAA, 1, 16'hBEEF, 16'h0000, 2'b00);
    wait_idle("t4");
    chk("t4_pkt_err_pulses", 32'(err_seen - eb), 32'd2);

    // 5: bursty source
    burst = 1;
    send_pkt(22'h000155, 6, 16'h0F0F, 16'h0203, 2'b00);
    wait_idle("t5");
    burst = 0;

    // 6: reset after the A1 byte
    src_q.push_back(8'hA5);
    src_q.push_back(8'h01);
    src_q.push_back(8'h20);
    src_q.push_back(8'h00);
    for (int i = 0; i < 200 && src_q.size() != 0; i++) @(negedge ft_clk);
    repeat (4) @(negedge ft_clk);
    chk("t6_busy_mid_pkt", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge ft_clk);
    chk("t6_oe",   32'(ft_oe),   32'd1);
    chk("t6_rd",   32'(ft_rd),   32'd1);
    chk("t6_wr",   32'(ft_wr),   32'd1);
    chk("t6_req",  32'(wr_req),  32'd0);
    chk("t6_addr", 32'(wr_addr), 32'd0);
    chk("t6_data", 32'(wr_data), 32'd0);
    chk("t6_err",  32'(pkt_err), 32'd0);
    chk("t6_busy", 32'(busy),    32'd0);
    reset = 1'b0;
    repeat (2) @(negedge ft_clk);
    send_pkt(22'h0ABCDE, 2, 16'h5A5A, 16'h0001, 2'b00);
    wait_idle("t6");

    chk("total_pkt_err", 32'(err_seen), 32'd2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
